// File: rtl/gcd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_unit
//  Purpose  : Iterative GCD engine with valid/ready handshakes on both sides.
//             Performs one reduction step per clock, using either Euclid by
//             subtraction (ALGO=0) or the binary Stein method (ALGO=1).
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             in_valid/in_ready - operand handshake (x_in, y_in)
//             out_valid/out_ready - result handshake
//             gcd_out           - gcd(x_in, y_in)
//             iter_count        - reduction steps taken (saturating)
//             zero_flag         - both operands were zero
//  Revision : 1.0 - initial release
// ============================================================================
module gcd_unit #(
    parameter int WIDTH = 8,
    parameter int ALGO  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] iter_count,
    output logic             zero_flag
);

    localparam int c_K_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_COMP = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [c_K_W-1:0] r_k;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_x_zero;
    logic             w_y_zero;
    logic             w_exit;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_x_step;
    logic [WIDTH-1:0] w_y_step;
    logic             w_k_inc;

    assign w_x_zero = (r_x == '0);
    assign w_y_zero = (r_y == '0);
    assign w_exit   = w_x_zero || w_y_zero || (r_x == r_y);

    // Exit-check result in priority order. For the subtractive algorithm r_k
    // stays zero, so the final shift is a no-op there.
    always_comb begin
        w_result = r_x << r_k;
        if (w_x_zero && w_y_zero) begin
            w_result = '0;
        end else if (w_x_zero) begin
            w_result = r_y;
        end else if (w_y_zero) begin
            w_result = r_x;
        end
    end

    // One reduction step of the selected algorithm.
    generate
        if (ALGO == 0) begin : g_subtractive
            always_comb begin
                w_x_step = r_x;
                w_y_step = r_y;
                w_k_inc  = 1'b0;
                if (r_x > r_y) begin
                    w_x_step = r_x - r_y;
                end else begin
                    w_y_step = r_y - r_x;
                end
            end
        end else begin : g_binary
            logic [WIDTH-1:0] w_diff_xy;
            logic [WIDTH-1:0] w_diff_yx;
            assign w_diff_xy = r_x - r_y;
            assign w_diff_yx = r_y - r_x;
            always_comb begin
                w_x_step = r_x;
                w_y_step = r_y;
                w_k_inc  = 1'b0;
                if (!r_x[0] && !r_y[0]) begin
                    // Common factor of two: remember it in k and restore at exit.
                    w_x_step = r_x >> 1;
                    w_y_step = r_y >> 1;
                    w_k_inc  = 1'b1;
                end else if (!r_x[0]) begin
                    w_x_step = r_x >> 1;
                end else if (!r_y[0]) begin
                    w_y_step = r_y >> 1;
                end else if (r_x > r_y) begin
                    w_x_step = w_diff_xy >> 1;
                end else begin
                    w_y_step = w_diff_yx >> 1;
                end
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (in_valid)  w_state_next = c_S_COMP;
            c_S_COMP: if (w_exit)    w_state_next = c_S_DONE;
            c_S_DONE: if (out_ready) w_state_next = c_S_IDLE;
            default:                 w_state_next = c_S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        r_x      <= x_in;
                        r_y      <= y_in;
                        r_k      <= '0;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_zero   <= 1'b0;
                    end
                end
                c_S_COMP: begin
                    if (w_exit) begin
                        r_result <= w_result;
                        r_zero   <= w_x_zero && w_y_zero;
                    end else begin
                        r_x <= w_x_step;
                        r_y <= w_y_step;
                        r_k <= r_k + c_K_W'(w_k_inc);
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (r_state == c_S_IDLE);
    assign out_valid  = (r_state == c_S_DONE);
    assign gcd_out    = r_result;
    assign iter_count = r_cnt;
    assign zero_flag  = r_zero;

endmodule
`default_nettype wire

// File: doc/gcd_unit.md
Name: gcd_unit

Overview:
- Self-contained GCD engine: controller FSM plus operand datapath, parametrised in operand width and algorithm.
- Accepts an operand pair over a valid/ready input handshake and iterates one reduction step per clock.
- Returns the result over a valid/ready output handshake, with an iteration count and a zero-operand flag.
- Successor to the fixed controller-only GCD FSM; intended as a drop-in arithmetic unit for lab datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- ALGO, 0, 0 = subtractive (Euclid by subtraction); 1 = binary (Stein).
- CNT_W, 8, width of iteration counter; counter saturates at 2^CNT_W−1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  unit can accept operands
- x_in  input  WIDTH  operand X, unsigned
- y_in  input  WIDTH  operand Y, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- gcd_out  output  WIDTH  gcd(X,Y)
- iter_count  output  CNT_W  reduction steps taken, saturating
- zero_flag  output  1  both operands were zero

Behaviour:
- Reset: one clock, synchronous, active-high. State IDLE; x, y, k, counter cleared. Outputs: in_ready=1, out_valid=0, gcd_out=0, iter_count=0, zero_flag=0.
- rst asserted in any state aborts the operation and returns to IDLE next edge; any in-flight result is discarded.
- States: IDLE, COMP, DONE.
- IDLE: in_ready=1. If in_valid, latch x=x_in, y=y_in, clear k and the counter, then go to COMP.
- COMP, first check (priority order):
  - x==0 and y==0: result 0, zero_flag=1, go to DONE.
  - x==0: result y, go to DONE.
  - y==0: result x, go to DONE.
  - x==y: result x<<k (k=0 for ALGO=0), go to DONE.
- COMP, ALGO=0 reduction step (when no check above fires): x>y gives x←x−y; otherwise y←y−x.
- COMP, ALGO=1 reduction step (first matching rule):
  - x and y both even: x←x>>1, y←y>>1, k←k+1.
  - x even: x←x>>1.
  - y even: y←y>>1.
  - both odd, x>y: x←(x−y)>>1.
  - both odd, otherwise: y←(y−x)>>1.
- The counter increments once per reduction step, saturating. The exit-check cycle does not count.
- k width is clog2(WIDTH)+1. x<<k never overflows WIDTH because gcd ≤ min(x_in, y_in).
- DONE: out_valid=1. gcd_out, iter_count and zero_flag are held stable until out_ready. in_ready=0. On out_ready, go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Latency: out_valid rises N+1 clock edges after the accepting edge, where N = iter_count (pre-saturation).
- Registers use non-blocking updates. Outputs decode from state plus registers with no combinational path from inputs to out_valid or gcd_out.
- in_ready depends only on state.

Test Plan:
- ALGO=0, x_in=12, y_in=8, out_ready held 1 -> out_valid 3 edges after accept; gcd_out=4, iter_count=2, zero_flag=0; in_ready back high the cycle after the out_valid cycle.
- ALGO=1, x_in=12, y_in=8 -> gcd_out=4, iter_count=4 (steps (6,4),(3,2),(3,1),(1,1)), out_valid 5 edges after accept.
- Zero operands, ALGO=0 and ALGO=1: (0,9) -> gcd_out=9, iter_count=0, out_valid 1 edge after accept; (0,0) -> gcd_out=0, zero_flag=1.
- Backpressure: (255,1) at WIDTH=8, ALGO=0, out_ready=0 for 10 cycles after out_valid -> outputs stable throughout; gcd_out=1, iter_count=254; then out_ready=1 for one cycle -> IDLE.
- Counter saturation: CNT_W=4, (255,1), ALGO=0 -> iter_count=15 and gcd_out=1.
- Reset mid-operation: assert rst for one cycle during COMP of (200,3) -> next cycle IDLE, out_valid=0, iter_count=0. A following request (9,6) then returns gcd_out=3 correctly.
